// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding common to the TX and (future) RX
// controllers, and the payload width fixed by the datapath PISO.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Clearable bit-period counter; bit_end flags the last clock of each bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic             bit_end
);

  logic [CNT_W-1:0] cnt_q;

  assign cnt     = cnt_q;
  assign bit_end = run && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer driving an external 8-bit PISO and the tx pin.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 piso_en,
  output logic                 piso_shift_load,
  output logic [DATA_BITS-1:0] piso_parallel_in,
  input  logic                 piso_serial_in,
  output logic                 tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W        = $clog2(DATA_BITS);

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 shift_load_q;
  logic                 handshake;
  logic                 sample;
  logic                 bit_end;
  logic [CNT_W-1:0]     baud_cnt;

  assign tx_ready         = (state_q == ST_IDLE);
  assign tx_busy          = !tx_ready;
  assign handshake        = tx_valid && tx_ready;
  assign tx               = tx_q;
  assign piso_parallel_in = data_q;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (handshake),
    .run    (tx_busy),
    .cnt    (baud_cnt),
    .bit_end(bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (handshake) begin
      parity_d = 1'b0;
    end else if (sample) begin
      parity_d = parity_q ^ piso_serial_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    data_d          = data_q;
    bit_cnt_d       = bit_cnt_q;
    tx_d            = tx_q;
    tx_done         = 1'b0;
    piso_en         = 1'b0;
    piso_shift_load = shift_load_q;
    sample          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (handshake) begin
          data_d    = tx_data;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          state_d   = ST_START;
        end
      end

      ST_START: begin
        if (baud_cnt == '0) begin
          piso_en         = 1'b1;
          piso_shift_load = 1'b0;
        end
        // Sample the PISO LSB onto the line, then shift it out.
        if (bit_end) begin
          tx_d            = piso_serial_in;
          sample          = 1'b1;
          piso_en         = 1'b1;
          piso_shift_load = 1'b1;
          state_d         = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d       = bit_cnt_q + BIT_W'(1);
            tx_d            = piso_serial_in;
            sample          = 1'b1;
            piso_en         = 1'b1;
            piso_shift_load = 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (bit_end) begin
          tx_done = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= 1'b1;
      shift_load_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      shift_load_q <= piso_shift_load;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural PISO; CLKS_PER_BIT = 4.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done;
  logic       piso_en, piso_shift_load;
  logic [7:0] piso_parallel_in;
  logic       piso_serial_in;
  logic       tx;
  logic [7:0] piso_q;

  int n_assert = 0;
  int n_fail   = 0;
  int n_loads  = 0;
  int n_shifts = 0;
  int n_done   = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .CLK_FREQ (50_000_000),
    .BAUD     (12_500_000),
    .DATA_BITS(8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_busy         (tx_busy),
    .tx_done         (tx_done),
    .piso_en         (piso_en),
    .piso_shift_load (piso_shift_load),
    .piso_parallel_in(piso_parallel_in),
    .piso_serial_in  (piso_serial_in),
    .tx              (tx)
  );

  // Behavioural PISO: load on shift_load=0, shift right on shift_load=1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      piso_q <= 8'h00;
    end else if (piso_en) begin
      if (!piso_shift_load) piso_q <= piso_parallel_in;
      else                  piso_q <= {1'b0, piso_q[7:1]};
    end
  end
  assign piso_serial_in = piso_q[0];

  always @(negedge clk) begin
    if (piso_en && !piso_shift_load) n_loads  <= n_loads + 1;
    if (piso_en &&  piso_shift_load) n_shifts <= n_shifts + 1;
    if (tx_done)                     n_done   <= n_done + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] b);
    logic [FRAME_BITS-1:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // Entered at a negedge with the DUT idle; handshake on the next posedge.
  // Returns at the negedge of cycle FRAME+1, where the next handshake may go.
  task automatic run_frame(input string tag, input logic [7:0] b, input logic hold_valid,
                           input logic [7:0] next_b, input int pulse_at);
    logic [FRAME_BITS-1:0] f;
    int loads0, shifts0, done0;
    f = frame_of(b);
    check({tag, " ready_before"}, tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    loads0   = n_loads;
    shifts0  = n_shifts;
    done0    = n_done;
    @(posedge clk);
    @(negedge clk);
    if (hold_valid) begin
      tx_data = next_b;
    end else begin
      tx_valid = 1'b0;
      tx_data  = ~b;
    end
    for (int c = 1; c <= FRAME; c++) begin
      if (pulse_at != 0 && c == pulse_at) begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
      end
      if (pulse_at != 0 && c == pulse_at + 1) tx_valid = 1'b0;
      check($sformatf("%s tx c%0d", tag, c), tx, f[(c-1)/CPB]);
      check($sformatf("%s done c%0d", tag, c), tx_done, (c == FRAME));
      check($sformatf("%s ready c%0d", tag, c), tx_ready, 0);
      check($sformatf("%s busy c%0d", tag, c), tx_busy, 1);
      @(negedge clk);
    end
    check({tag, " ready_after"}, tx_ready, 1);
    check({tag, " tx_idle"}, tx, 1);
    check({tag, " loads"}, n_loads - loads0, 1);
    check({tag, " shifts"}, n_shifts - shifts0, 8);
    check({tag, " dones"}, n_done - done0, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " tx"}, tx, 1);
    check({tag, " ready"}, tx_ready, 1);
    check({tag, " busy"}, tx_busy, 0);
    check({tag, " done"}, tx_done, 0);
    check({tag, " piso_en"}, piso_en, 0);
    check({tag, " shift_load"}, piso_shift_load, 1);
    check({tag, " par_in"}, piso_parallel_in, 8'h00);
  endtask

  initial begin
    int done0;
    rst      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;
    @(negedge clk);

    // 0xC9: line 0,1,0,0,1,0,0,1,1,(parity),1
    run_frame("c9", 8'hC9, 1'b0, 8'h00, 0);

    // Back-to-back with tx_valid held: second start bit 41 cycles after first.
    run_frame("0f_b2b", 8'h0F, 1'b1, 8'hA5, 0);
    run_frame("a5_b2b", 8'hA5, 1'b0, 8'h00, 0);

    // 0x55 pulsed mid-frame must be ignored.
    @(negedge clk);
    run_frame("0f_ign", 8'h0F, 1'b0, 8'h00, 20);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ign idle tx %0d", i), tx, 1);
      check($sformatf("ign idle busy %0d", i), tx_busy, 0);
      @(negedge clk);
    end

    // Reset at cycle 18 of a 0xFF frame aborts at once.
    check("ff ready", tx_ready, 1);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    done0    = n_done;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("ff busy c18", tx_busy, 1);
    check("ff tx c18", tx, 1);
    rst = 1'b1;
    #1;
    check("ff async busy", tx_busy, 0);
    check("ff async ready", tx_ready, 1);
    check("ff async tx", tx, 1);
    check("ff async piso_en", piso_en, 0);
    repeat (2) @(negedge clk);
    check_reset_values("ff rst");
    check("ff no done", n_done - done0, 0);
    rst = 1'b0;
    run_frame("81", 8'h81, 1'b0, 8'h00, 0);

`ifdef UART_TX_PARITY_EN
    run_frame("07_par", 8'h07, 1'b0, 8'h00, 0);
    run_frame("03_par", 8'h03, 1'b0, 8'h00, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
